// File: rtl/hazard_ctrl_if.sv
// Bundle between the datapath and the hazard/pipeline control unit.
interface hazard_ctrl_if #(
   parameter int RA_BIT    = 5,
   parameter int CNT_WIDTH = 32
);
   logic [RA_BIT-1:0]    id_rs;
   logic [RA_BIT-1:0]    id_rt;
   logic                 id_rs_used;
   logic                 id_rt_used;
   logic [RA_BIT-1:0]    ex_rs;
   logic [RA_BIT-1:0]    ex_rt;
   logic [RA_BIT-1:0]    ex_req_w;
   logic                 ex_w_en;
   logic                 ex_is_load;
   logic [RA_BIT-1:0]    dm_req_w;
   logic                 dm_w_en;
   logic [RA_BIT-1:0]    wb_req_w;
   logic                 wb_w_en;
   logic                 ex_redirect;
   logic                 dm_busy;
   logic                 wb_halt;
   logic                 resume;

   logic                 pc_en;
   logic                 if_id_en;
   logic                 id_ex_en;
   logic                 ex_dm_en;
   logic                 dm_wb_en;
   logic                 if_id_clr_n;
   logic                 id_ex_clr_n;
   logic                 ex_dm_clr_n;
   logic                 dm_wb_clr_n;
   logic [1:0]           fwd_a;
   logic [1:0]           fwd_b;
   logic                 halted;
   logic [CNT_WIDTH-1:0] stall_cnt;
   logic [CNT_WIDTH-1:0] flush_cnt;

   // Datapath side: supplies pipeline status, consumes control.
   modport master (
      output id_rs, id_rt, id_rs_used, id_rt_used, ex_rs, ex_rt, ex_req_w,
             ex_w_en, ex_is_load, dm_req_w, dm_w_en, wb_req_w, wb_w_en,
             ex_redirect, dm_busy, wb_halt, resume,
      input  pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en, if_id_clr_n,
             id_ex_clr_n, ex_dm_clr_n, dm_wb_clr_n, fwd_a, fwd_b, halted,
             stall_cnt, flush_cnt
   );

   // Control unit side.
   modport slave (
      input  id_rs, id_rt, id_rs_used, id_rt_used, ex_rs, ex_rt, ex_req_w,
             ex_w_en, ex_is_load, dm_req_w, dm_w_en, wb_req_w, wb_w_en,
             ex_redirect, dm_busy, wb_halt, resume,
      output pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en, if_id_clr_n,
             id_ex_clr_n, ex_dm_clr_n, dm_wb_clr_n, fwd_a, fwd_b, halted,
             stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: stalls, flushes, halt sequencing, forwarding.
//
//   state  | meaning
//   RUN    | pipeline advancing, hazards resolved by stall/flush
//   HALTED | halting syscall retired, everything frozen until resume
module hazard_ctrl #(
   parameter int CNT_WIDTH = 32,
   parameter int RA_BIT    = 5
) (
   input logic         clk,
   input logic         rst,
   hazard_ctrl_if.slave hz
);
   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

   state_t state, state_nxt;
   logic   load_use;
   logic   stall_ev, flush_ev;
   logic   pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en;
   logic   if_id_clr_n, id_ex_clr_n, ex_dm_clr_n, dm_wb_clr_n;
   logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;

   assign load_use = hz.ex_is_load && hz.ex_w_en && (hz.ex_req_w != '0) &&
                     ((hz.id_rs_used && (hz.id_rs == hz.ex_req_w)) ||
                      (hz.id_rt_used && (hz.id_rt == hz.ex_req_w)));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   // Next state: halt wins over a coincident resume.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:    if (hz.wb_halt) state_nxt = HALTED;
         HALTED: if (hz.resume)  state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // Stage control in priority order; rst forces the free-running defaults.
   always_comb begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_dm_en    = 1'b1;
      dm_wb_en    = 1'b1;
      if_id_clr_n = 1'b1;
      id_ex_clr_n = 1'b1;
      ex_dm_clr_n = 1'b1;
      dm_wb_clr_n = 1'b1;
      stall_ev    = 1'b0;
      flush_ev    = 1'b0;
      if (rst) begin
         stall_ev = 1'b0;
      end else if (state == HALTED) begin
         {pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en} = '0;
      end else if (hz.wb_halt || hz.dm_busy) begin
         // Frozen stages hold their inputs; deferred hazards re-evaluate later.
         {pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en} = '0;
         stall_ev = 1'b1;
      end else if (hz.ex_redirect) begin
         // The ID instruction is discarded, so a load-use on it is moot.
         if_id_clr_n = 1'b0;
         id_ex_clr_n = 1'b0;
         flush_ev    = 1'b1;
      end else if (load_use) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_clr_n = 1'b0;
         stall_ev    = 1'b1;
      end
   end

   // Saturating performance counters; events never fire in HALTED.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_ev && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
         if (flush_ev && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      end
   end

   function automatic logic [1:0] fwd_sel(input logic [RA_BIT-1:0] src);
      if (hz.dm_w_en && (hz.dm_req_w != '0) && (hz.dm_req_w == src))
         return 2'd1;
      else if (hz.wb_w_en && (hz.wb_req_w != '0) && (hz.wb_req_w == src))
         return 2'd2;
      else
         return 2'd0;
   endfunction

   // Forwarding selects: DM result is younger than WB data, so it wins.
   always_comb begin
      hz.fwd_a = fwd_sel(hz.ex_rs);
      hz.fwd_b = fwd_sel(hz.ex_rt);
   end

   assign hz.pc_en       = pc_en;
   assign hz.if_id_en    = if_id_en;
   assign hz.id_ex_en    = id_ex_en;
   assign hz.ex_dm_en    = ex_dm_en;
   assign hz.dm_wb_en    = dm_wb_en;
   assign hz.if_id_clr_n = if_id_clr_n;
   assign hz.id_ex_clr_n = id_ex_clr_n;
   assign hz.ex_dm_clr_n = ex_dm_clr_n;
   assign hz.dm_wb_clr_n = dm_wb_clr_n;
   assign hz.halted      = (state == HALTED) && !rst;
   assign hz.stall_cnt   = stall_cnt;
   assign hz.flush_cnt   = flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: expected vectors queued as each cycle is driven,
// captured outputs compared per scenario.
module tb_hazard_ctrl;
   localparam int CW = 4;
   localparam int RB = 5;

   // ctl = {pc_en, if_id_en, id_ex_en, ex_dm_en, dm_wb_en, clr_n x4}
   localparam logic [8:0] DEF = 9'b1_1111_1111;
   localparam logic [8:0] FRZ = 9'b0_0000_1111;
   localparam logic [8:0] LU  = 9'b0_0111_1011;
   localparam logic [8:0] RD  = 9'b1_1111_0011;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hazard_ctrl_if #(.RA_BIT(RB), .CNT_WIDTH(CW)) hz ();
   hazard_ctrl #(.CNT_WIDTH(CW), .RA_BIT(RB)) dut (.clk(clk), .rst(rst), .hz(hz.slave));

   // packed = {ctl[8:0], fwd_a, fwd_b, halted, stall[3:0], flush[3:0]}
   logic [21:0] exp_q[$];
   logic [21:0] act_q[$];
   string       name_q[$];
   int          errors = 0;
   int          checks = 0;
   logic [CW-1:0] m_stall = '0;
   logic [CW-1:0] m_flush = '0;

   task automatic idle();
      hz.id_rs = '0; hz.id_rt = '0; hz.id_rs_used = 0; hz.id_rt_used = 0;
      hz.ex_rs = '0; hz.ex_rt = '0; hz.ex_req_w = '0; hz.ex_w_en = 0;
      hz.ex_is_load = 0; hz.dm_req_w = '0; hz.dm_w_en = 0; hz.wb_req_w = '0;
      hz.wb_w_en = 0; hz.ex_redirect = 0; hz.dm_busy = 0; hz.wb_halt = 0;
      hz.resume = 0; rst = 0;
   endtask

   // Queue the expectation for the cycle now being driven, capture the DUT
   // output mid-cycle, then advance the bench counter model past the edge.
   task automatic step(input string n, input logic [8:0] c, input logic [3:0] f,
                       input logic h, input bit st, input bit fl, input bit rs);
      exp_q.push_back({c, f, h, m_stall, m_flush});
      name_q.push_back(n);
      @(negedge clk);
      act_q.push_back({hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_dm_en, hz.dm_wb_en,
                       hz.if_id_clr_n, hz.id_ex_clr_n, hz.ex_dm_clr_n, hz.dm_wb_clr_n,
                       hz.fwd_a, hz.fwd_b, hz.halted, hz.stall_cnt, hz.flush_cnt});
      @(posedge clk); #1;
      if (rs) begin
         m_stall = '0;
         m_flush = '0;
      end else begin
         if (st && m_stall != '1) m_stall = m_stall + 1'b1;
         if (fl && m_flush != '1) m_flush = m_flush + 1'b1;
      end
   endtask

   task automatic test_reset();
      logic [21:0] e, a;
      string n;
      idle(); rst = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      step("reset_hold", DEF, 4'd0, 0, 0, 0, 1);
      idle();
      step("after_reset", DEF, 4'd0, 0, 0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n = name_q.pop_front();
         a = (act_q.size() > 0) ? act_q.pop_front() : 22'bx;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got ctl=%b fwd=%b halt=%b st=%0d fl=%0d, want ctl=%b fwd=%b halt=%b st=%0d fl=%0d",
                     n, a[21:13], a[12:9], a[8], a[7:4], a[3:0], e[21:13], e[12:9], e[8], e[7:4], e[3:0]);
         end
      end
   endtask

   task automatic test_load_use();
      logic [21:0] e, a;
      string n;
      idle(); hz.ex_is_load = 1; hz.ex_w_en = 1; hz.ex_req_w = 8;
      hz.id_rs = 8; hz.id_rs_used = 1;
      step("lu_rs", LU, 4'd0, 0, 1, 0, 0);
      idle();
      step("lu_cleared", DEF, 4'd0, 0, 0, 0, 0);
      hz.ex_is_load = 1; hz.ex_w_en = 1; hz.ex_req_w = 0; hz.id_rs = 0; hz.id_rs_used = 1;
      step("lu_r0", DEF, 4'd0, 0, 0, 0, 0);
      hz.ex_req_w = 8; hz.id_rs = 8; hz.id_rs_used = 0;
      step("lu_rs_unused", DEF, 4'd0, 0, 0, 0, 0);
      hz.id_rt = 8; hz.id_rt_used = 1;
      step("lu_rt", LU, 4'd0, 0, 1, 0, 0);
      hz.ex_w_en = 0;
      step("lu_no_wen", DEF, 4'd0, 0, 0, 0, 0);
      idle();
      step("lu_idle", DEF, 4'd0, 0, 0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n = name_q.pop_front();
         a = (act_q.size() > 0) ? act_q.pop_front() : 22'bx;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got ctl=%b fwd=%b halt=%b st=%0d fl=%0d, want ctl=%b fwd=%b halt=%b st=%0d fl=%0d",
                     n, a[21:13], a[12:9], a[8], a[7:4], a[3:0], e[21:13], e[12:9], e[8], e[7:4], e[3:0]);
         end
      end
   endtask

   task automatic test_redirect();
      logic [21:0] e, a;
      string n;
      idle(); hz.ex_redirect = 1;
      hz.ex_is_load = 1; hz.ex_w_en = 1; hz.ex_req_w = 8; hz.id_rs = 8; hz.id_rs_used = 1;
      step("redir_lu", RD, 4'd0, 0, 0, 1, 0);
      idle();
      step("redir_after", DEF, 4'd0, 0, 0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n = name_q.pop_front();
         a = (act_q.size() > 0) ? act_q.pop_front() : 22'bx;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got ctl=%b fwd=%b halt=%b st=%0d fl=%0d, want ctl=%b fwd=%b halt=%b st=%0d fl=%0d",
                     n, a[21:13], a[12:9], a[8], a[7:4], a[3:0], e[21:13], e[12:9], e[8], e[7:4], e[3:0]);
         end
      end
   endtask

   task automatic test_dm_busy();
      logic [21:0] e, a;
      string n;
      idle(); hz.ex_redirect = 1; hz.dm_busy = 1;
      for (int i = 0; i < 3; i++) step($sformatf("busy_%0d", i), FRZ, 4'd0, 0, 1, 0, 0);
      hz.dm_busy = 0;
      step("busy_flush", RD, 4'd0, 0, 0, 1, 0);
      idle();
      step("busy_after", DEF, 4'd0, 0, 0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n = name_q.pop_front();
         a = (act_q.size() > 0) ? act_q.pop_front() : 22'bx;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got ctl=%b fwd=%b halt=%b st=%0d fl=%0d, want ctl=%b fwd=%b halt=%b st=%0d fl=%0d",
                     n, a[21:13], a[12:9], a[8], a[7:4], a[3:0], e[21:13], e[12:9], e[8], e[7:4], e[3:0]);
         end
      end
   endtask

   task automatic test_forward();
      logic [21:0] e, a;
      string n;
      idle(); hz.ex_rs = 5; hz.dm_req_w = 5; hz.wb_req_w = 5; hz.dm_w_en = 1; hz.wb_w_en = 1;
      step("fwd_dm_pri", DEF, 4'b01_00, 0, 0, 0, 0);
      hz.dm_w_en = 0;
      step("fwd_wb", DEF, 4'b10_00, 0, 0, 0, 0);
      hz.ex_rs = 0; hz.ex_rt = 0; hz.dm_req_w = 0; hz.wb_req_w = 0; hz.dm_w_en = 1;
      step("fwd_r0", DEF, 4'b00_00, 0, 0, 0, 0);
      hz.ex_rt = 9; hz.dm_req_w = 9; hz.wb_req_w = 9;
      step("fwd_b_dm", DEF, 4'b00_01, 0, 0, 0, 0);
      hz.ex_rs = 9; hz.dm_req_w = 3;
      step("fwd_ab_wb", DEF, 4'b10_10, 0, 0, 0, 0);
      hz.wb_w_en = 0;
      step("fwd_none", DEF, 4'b00_00, 0, 0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n = name_q.pop_front();
         a = (act_q.size() > 0) ? act_q.pop_front() : 22'bx;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got ctl=%b fwd=%b halt=%b st=%0d fl=%0d, want ctl=%b fwd=%b halt=%b st=%0d fl=%0d",
                     n, a[21:13], a[12:9], a[8], a[7:4], a[3:0], e[21:13], e[12:9], e[8], e[7:4], e[3:0]);
         end
      end
   endtask

   task automatic test_halt();
      logic [21:0] e, a;
      string n;
      idle(); hz.wb_halt = 1;
      step("halt_enter", FRZ, 4'd0, 0, 1, 0, 0);
      idle(); hz.ex_redirect = 1; hz.dm_busy = 1;
      for (int i = 0; i < 10; i++) step($sformatf("halt_hold_%0d", i), FRZ, 4'd0, 1, 0, 0, 0);
      idle(); hz.resume = 1;
      step("halt_resume", FRZ, 4'd0, 1, 0, 0, 0);
      idle();
      step("halt_left", DEF, 4'd0, 0, 0, 0, 0);
      hz.resume = 1;
      step("resume_in_run", DEF, 4'd0, 0, 0, 0, 0);
      hz.wb_halt = 1;
      step("halt_and_resume", FRZ, 4'd0, 0, 1, 0, 0);
      idle();
      step("halt_wins", FRZ, 4'd0, 1, 0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n = name_q.pop_front();
         a = (act_q.size() > 0) ? act_q.pop_front() : 22'bx;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got ctl=%b fwd=%b halt=%b st=%0d fl=%0d, want ctl=%b fwd=%b halt=%b st=%0d fl=%0d",
                     n, a[21:13], a[12:9], a[8], a[7:4], a[3:0], e[21:13], e[12:9], e[8], e[7:4], e[3:0]);
         end
      end
   endtask

   task automatic test_reset_halted();
      logic [21:0] e, a;
      string n;
      // Still HALTED from the previous scenario, stall count is 7 here.
      idle(); rst = 1;
      step("rst_in_halt", DEF, 4'd0, 0, 0, 0, 1);
      idle();
      step("rst_halt_after", DEF, 4'd0, 0, 0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n = name_q.pop_front();
         a = (act_q.size() > 0) ? act_q.pop_front() : 22'bx;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got ctl=%b fwd=%b halt=%b st=%0d fl=%0d, want ctl=%b fwd=%b halt=%b st=%0d fl=%0d",
                     n, a[21:13], a[12:9], a[8], a[7:4], a[3:0], e[21:13], e[12:9], e[8], e[7:4], e[3:0]);
         end
      end
   endtask

   task automatic test_saturate();
      logic [21:0] e, a;
      string n;
      idle(); hz.dm_busy = 1;
      for (int i = 0; i < 17; i++) step($sformatf("sat_stall_%0d", i), FRZ, 4'd0, 0, 1, 0, 0);
      idle(); hz.ex_redirect = 1;
      for (int i = 0; i < 17; i++) step($sformatf("sat_flush_%0d", i), RD, 4'd0, 0, 0, 1, 0);
      idle(); hz.dm_busy = 1; rst = 1;
      step("rst_mid_stall", DEF, 4'd0, 0, 0, 0, 1);
      idle();
      step("sat_cleared", DEF, 4'd0, 0, 0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n = name_q.pop_front();
         a = (act_q.size() > 0) ? act_q.pop_front() : 22'bx;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got ctl=%b fwd=%b halt=%b st=%0d fl=%0d, want ctl=%b fwd=%b halt=%b st=%0d fl=%0d",
                     n, a[21:13], a[12:9], a[8], a[7:4], a[3:0], e[21:13], e[12:9], e[8], e[7:4], e[3:0]);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load_use();
      test_redirect();
      test_dm_busy();
      test_forward();
      test_halt();
      test_reset_halted();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit that drives the enable and active-low clear inputs of the four inter-stage registers (IF/ID, ID/EX, EX/DM, DM/WB) and the PC enable.
- Detects load-use hazards, branch/jump redirects, data-memory wait states and syscall halt.
- Produces EX-stage forwarding selects.
- Sits beside the datapath in the core and owns the run/halt state machine plus performance counters.

Parameters:
CNT_WIDTH, 32, width of stall_cnt and flush_cnt.
RA_BIT, 5, register-address width.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
id_rs, id_rt  in  RA_BIT each  source registers of the instruction in ID
id_rs_used, id_rt_used  in  1 each  ID instruction reads rs / rt
ex_rs, ex_rt  in  RA_BIT each  source registers of the instruction in EX
ex_req_w  in  RA_BIT  EX destination register
ex_w_en  in  1  EX writes the register file
ex_is_load  in  1  EX instruction is a load
dm_req_w, dm_w_en  in  RA_BIT, 1  DM-stage destination register and write enable
wb_req_w, wb_w_en  in  RA_BIT, 1  WB-stage destination register and write enable
ex_redirect  in  1  branch taken or jump resolved in EX
dm_busy  in  1  data memory not ready this cycle
wb_halt  in  1  halting syscall in WB
resume  in  1  single-cycle pulse that leaves HALTED
pc_en  out  1  PC update enable
if_id_en, id_ex_en, ex_dm_en, dm_wb_en  out  1 each  stage enables, 1 = load
if_id_clr_n, id_ex_clr_n, ex_dm_clr_n, dm_wb_clr_n  out  1 each  stage clears, 0 = insert bubble
fwd_a, fwd_b  out  2 each  EX operand source: 0 = register file, 1 = DM-stage result, 2 = WB-stage data
halted  out  1  core is in HALTED
stall_cnt, flush_cnt  out  CNT_WIDTH each  performance counters

Behaviour:
- Reset: one clock, clk; synchronous active-high reset, rst, sampled on the rising edge.
  - rst = 1 forces state RUN and clears both counters to 0.
  - Outputs while rst = 1: all en = 1, all clr_n = 1, pc_en = 1, halted = 0.
- FSM, two states (RUN, HALTED), registered.
  - RUN -> HALTED when wb_halt = 1.
  - HALTED -> RUN when resume = 1.
  - resume in RUN is ignored.
- Control outputs are combinational from state and inputs. Evaluate in priority order, first match wins:
  1. State HALTED: pc_en and all en = 0; all clr_n = 1.
  2. RUN with wb_halt = 1: same as HALTED for this cycle. wb_halt and resume in the same cycle: halt wins.
  3. RUN with dm_busy = 1: pc_en and all en = 0; clr_n = 1. Redirect and load-use are deferred; the frozen stages hold their inputs, so they are re-evaluated once busy drops.
  4. RUN with ex_redirect = 1:
     - pc_en = 1, if_id_clr_n = 0, id_ex_clr_n = 0.
     - All other outputs take default values.
     - Any concurrent load-use condition is ignored, because the ID instruction is flushed.
  5. RUN with load-use = 1: pc_en = 0, if_id_en = 0, id_ex_clr_n = 0; all other outputs default. This is a 1-cycle bubble.
     - load-use = ex_is_load & ex_w_en & (ex_req_w != 0) & ((id_rs_used & id_rs == ex_req_w) | (id_rt_used & id_rt == ex_req_w)).
  6. Default: all en = 1, all clr_n = 1, pc_en = 1.
- Forwarding (combinational, independent of the FSM), fwd_a:
  - 1 if dm_w_en & dm_req_w != 0 & dm_req_w == ex_rs;
  - else 2 if wb_w_en & wb_req_w != 0 & wb_req_w == ex_rs;
  - else 0.
  - The DM stage takes priority over WB. fwd_b is identical using ex_rt. Register 0 is never forwarded.
- Counters, registered:
  - stall_cnt +1 on each RUN cycle with pc_en = 0 (rules 2, 3, 5).
  - flush_cnt +1 on each rule-4 cycle.
  - Both saturate at all-ones, hold in HALTED, and clear only on rst.
- halted = 1 exactly while state = HALTED. It rises on the cycle after wb_halt.
- rst asserted mid-halt or mid-stall: next cycle is RUN with default outputs.

Test Plan:
- Load-use: EX = lw $8 (ex_is_load = 1, ex_w_en = 1, ex_req_w = 8), ID reads rs = 8 -> same cycle pc_en = 0, if_id_en = 0, id_ex_clr_n = 0; stall_cnt 0 -> 1; next cycle, with the hazard removed, outputs return to default. Repeat with ex_req_w = 0 -> no stall.
- Redirect + load-use together: ex_redirect = 1 and load-use = 1 -> pc_en = 1, if_id_clr_n = 0, id_ex_clr_n = 0, if_id_en = 1; flush_cnt +1, stall_cnt unchanged.
- dm_busy held 3 cycles, with ex_redirect = 1 throughout -> 3 cycles of all en = 0 with no clears; stall_cnt +3; the flush fires on the first cycle after busy drops.
- Forwarding: ex_rs = 5, dm_req_w = 5, wb_req_w = 5, both w_en = 1 -> fwd_a = 1. With dm_w_en = 0 -> fwd_a = 2. With ex_rt = 0 and both stages writing register 0 -> fwd_b = 0.
- Halt: wb_halt pulse -> that cycle all en = 0; halted = 1 from the next cycle. resume held 0 for 10 cycles -> outputs frozen, counters unchanged. resume pulse -> halted = 0 and default outputs the next cycle. wb_halt and resume in the same RUN cycle -> HALTED.
- Reset: assert rst in HALTED with stall_cnt = 7 -> next cycle halted = 0, stall_cnt = 0, flush_cnt = 0, all en = 1. Also force stall_cnt to all-ones and stall once -> value stays all-ones.
